// File: rtl/tile_spawner_pkg.sv
// Shared game definitions for the 4x4 board: cell geometry, tile codes and
// the spawner FSM encoding.
package tile_spawner_pkg;

    localparam int N_CELLS = 16;
    localparam int CELL_W  = 4;
    localparam int IDX_W   = 4;
    localparam int BOARD_W = N_CELLS * CELL_W;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t CELL_EMPTY    = 4'd0;
    localparam cell_t TWO_CODE_DEF  = 4'd1;
    localparam cell_t FOUR_CODE_DEF = 4'd2;
    localparam idx_t  LAST_CNT      = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tile_spawner_if.sv
// Request/board/write-port bundle between the game controller (master) and
// the tile spawner (slave).
interface tile_spawner_if;
    import tile_spawner_pkg::*;

    logic               i_start;
    idx_t               i_rand;
    logic               i_two_or_four;
    logic [BOARD_W-1:0] i_board;
    logic               o_busy;
    logic               o_wr_en;
    idx_t               o_wr_addr;
    cell_t              o_wr_val;
    logic               o_done;
    logic               o_full;

    modport master (
        output i_start, i_rand, i_two_or_four, i_board,
        input  o_busy, o_wr_en, o_wr_addr, o_wr_val, o_done, o_full
    );

    modport slave (
        input  i_start, i_rand, i_two_or_four, i_board,
        output o_busy, o_wr_en, o_wr_addr, o_wr_val, o_done, o_full
    );

endinterface

// File: rtl/tile_spawner_board_cell_sel.sv
// Combinational 16:1 selector returning the 4-bit cell at a given index of
// the packed board vector.
module board_cell_sel
    import tile_spawner_pkg::*;
(
    input  logic [BOARD_W-1:0] i_board,
    input  idx_t               i_idx,
    output cell_t              o_cell
);

    cell_t w_cells [N_CELLS];

    for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
        assign w_cells[g] = i_board[g*CELL_W +: CELL_W];
    end

    assign o_cell = w_cells[i_idx];

endmodule

// File: rtl/tile_spawner.sv
// Places a new 2/4 tile in the first empty cell at or after a random index,
// wrapping around the board; reports "full" when no empty cell exists.
module tile_spawner
    import tile_spawner_pkg::*;
#(
    parameter cell_t TWO_CODE  = TWO_CODE_DEF,
    parameter cell_t FOUR_CODE = FOUR_CODE_DEF
) (
    input  logic           clk,
    input  logic           rst,    // asynchronous, active low
    tile_spawner_if.slave  bus
);

    state_t r_state;
    state_t w_state_nxt;
    idx_t   r_idx;
    idx_t   r_cnt;
    cell_t  r_val;
    logic   r_full;
    idx_t   r_wr_addr;
    cell_t  r_wr_val;
    cell_t  w_cell;
    logic   w_cell_empty;

    board_cell_sel u_cell_sel (
        .i_board (bus.i_board),
        .i_idx   (r_idx),
        .o_cell  (w_cell)
    );

    assign w_cell_empty = (w_cell == CELL_EMPTY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: the default assignment comes first so every path drives
    // w_state_nxt; a missing branch would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.i_start) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (w_cell_empty)            w_state_nxt = ST_WRITE;
                else if (r_cnt == LAST_CNT)  w_state_nxt = ST_DONE;
            end
            ST_WRITE: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all state here updates with non-blocking assignments so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_val     <= '0;
            r_full    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_val  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // full stays visible to the controller until the next request
                    if (bus.i_start) begin
                        r_idx  <= bus.i_rand;
                        r_val  <= bus.i_two_or_four ? TWO_CODE : FOUR_CODE;
                        r_cnt  <= '0;
                        r_full <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_cell_empty) begin
                        r_wr_addr <= r_idx;
                        r_wr_val  <= r_val;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == LAST_CNT) r_full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy    = (r_state != ST_IDLE);
    assign bus.o_wr_en   = (r_state == ST_WRITE);
    assign bus.o_done    = (r_state == ST_DONE);
    assign bus.o_full    = r_full;
    assign bus.o_wr_addr = r_wr_addr;
    assign bus.o_wr_val  = r_wr_val;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed and swept checks of tile_spawner: latency, wrap-around, full board,
// start-while-busy, async reset abort and output hold behaviour.
module tb_tile_spawner;
    import tile_spawner_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    tile_spawner_if bus ();

    tile_spawner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cell_of(input logic [63:0] brd, input logic [3:0] a);
        return brd[int'(a)*4 +: 4];
    endfunction

    function automatic void model(input logic [63:0] brd, input logic [3:0] rnd,
                                  output bit full, output logic [3:0] addr, output int k);
        logic [3:0] a;
        full = 1'b1;
        addr = 4'd0;
        k    = 0;
        for (int j = 0; j < 16; j++) begin
            a = rnd + 4'(j);
            if (cell_of(brd, a) == 4'd0) begin
                full = 1'b0;
                addr = a;
                k    = j;
                break;
            end
        end
    endfunction

    // Caller is at a negedge. The next rising edge samples start (edge T);
    // the negedge after edge T+n-1 observes cycle T+n, counted as off = n.
    task automatic run_spawn(input string tag, input logic [63:0] brd, input logic [3:0] rnd,
                             input logic tof, input bit repulse, input bit exp_full,
                             input logic [3:0] exp_addr, input logic [3:0] exp_val, input int exp_k);
        int         wr_cnt = 0;
        int         done_cnt = 0;
        int         wr_off = 0;
        int         done_off = 0;
        int         idle_off = 0;
        logic [3:0] got_addr = 4'd0;
        logic [3:0] got_val = 4'd0;
        logic       got_full = 1'b0;
        bus.i_board       = brd;
        bus.i_rand        = rnd;
        bus.i_two_or_four = tof;
        bus.i_start       = 1'b1;
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            bus.i_start = repulse && (off == 1 || off == 2);
            if (off == 1) begin
                bus.i_rand        = ~rnd;
                bus.i_two_or_four = ~tof;
            end
            if (bus.o_wr_en) begin
                wr_cnt++;
                if (wr_cnt == 1) begin
                    wr_off   = off;
                    got_addr = bus.o_wr_addr;
                    got_val  = bus.o_wr_val;
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_off = off;
                    got_full = bus.o_full;
                end
            end
            if (!bus.o_busy && idle_off == 0) idle_off = off;
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_full_at_done"}, got_full, exp_full);
        check({tag, "_busy_low_off"}, idle_off, (exp_full ? 17 : exp_k + 3) + 1);
        check({tag, "_full_hold"}, bus.o_full, exp_full);
        if (exp_full) begin
            check({tag, "_wr_cnt"}, wr_cnt, 0);
            check({tag, "_done_off"}, done_off, 17);
        end else begin
            check({tag, "_wr_cnt"}, wr_cnt, 1);
            check({tag, "_wr_off"}, wr_off, exp_k + 2);
            check({tag, "_wr_addr"}, got_addr, exp_addr);
            check({tag, "_wr_val"}, got_val, exp_val);
            check({tag, "_cell_was_empty"}, cell_of(brd, got_addr), 4'd0);
            check({tag, "_done_off"}, done_off, exp_k + 3);
            check({tag, "_addr_hold"}, bus.o_wr_addr, exp_addr);
            check({tag, "_val_hold"}, bus.o_wr_val, exp_val);
        end
    endtask

    initial begin
        logic [63:0] brd;
        bit          m_full;
        logic [3:0]  m_addr;
        logic [3:0]  rnd;
        logic        tof;
        int          m_k;
        int          stray;

        bus.i_start       = 1'b0;
        bus.i_rand        = 4'd0;
        bus.i_two_or_four = 1'b0;
        bus.i_board       = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.o_busy, 0);
        check("rst_wr_en", bus.o_wr_en, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_full", bus.o_full, 0);
        check("rst_wr_addr", bus.o_wr_addr, 0);
        check("rst_wr_val", bus.o_wr_val, 0);

        // First start lands on the very first rising edge after release.
        rst = 1'b1;
        run_spawn("empty_r5", 64'h0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 4'd1, 0);

        // Idle with start low: rand/two_or_four toggling must not wake it.
        for (int i = 0; i < 4; i++) begin
            bus.i_rand        = 4'(i * 5);
            bus.i_two_or_four = i[0];
            @(negedge clk);
        end
        check("idle_no_busy", bus.o_busy, 0);

        run_spawn("wrap_r14", 64'h3500_0000_0000_0007, 4'd14, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 3);
        run_spawn("full_board", 64'hFEDC_BA98_7654_3219, 4'd9, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 0);
        run_spawn("repulse", 64'h0000_0000_0006_6000, 4'd3, 1'b1, 1'b1, 1'b0, 4'd5, 4'd1, 2);

        // Asynchronous reset in the middle of a long scan.
        bus.i_board = 64'hFEDC_BA98_7654_3219;
        bus.i_rand  = 4'd2;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", bus.o_busy, 1);
        bus.i_board = 64'h0;
        #2 rst = 1'b0;
        #1;
        check("async_busy", bus.o_busy, 0);
        check("async_wr_en", bus.o_wr_en, 0);
        check("async_done", bus.o_done, 0);
        check("async_full", bus.o_full, 0);
        check("async_wr_addr", bus.o_wr_addr, 0);
        check("async_wr_val", bus.o_wr_val, 0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.o_wr_en || bus.o_done || bus.o_busy) stray++;
        end
        check("post_rst_quiet", stray, 0);
        run_spawn("after_rst", 64'h0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 4'd1, 0);

        // Random sweep against the reference scan.
        for (int it = 0; it < 16; it++) begin
            for (int c = 0; c < 16; c++)
                brd[c*4 +: 4] = ($urandom_range(0, 2) == 0 && it != 5) ? 4'd0 : 4'($urandom_range(1, 15));
            rnd = 4'($urandom_range(0, 15));
            tof = 1'($urandom_range(0, 1));
            model(brd, rnd, m_full, m_addr, m_k);
            run_spawn($sformatf("sweep%0d", it), brd, rnd, tof, 1'b0, m_full, m_addr,
                      tof ? 4'd1 : 4'd2, m_k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
